// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage in front of the control decoder.
// Owns the PC, issues in-order word fetches to instruction memory, buffers
// returned words in a small prefetch FIFO and hands them to decode with a
// valid/ready handshake. A redirect (pc_sel) reloads the PC, flushes the
// buffered words and squashes responses for requests already in flight.
//
// Build option: define IFETCH_BYPASS_EN to let a response go straight to
// decode in the same cycle when the FIFO is empty and nothing is being
// dropped. Without it every response is written to the FIFO first.

// Run-time checks on the fetch buffer bookkeeping; instantiated by ifetch_unit.
module ifetch_unit_chk #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          full_i,
  input  logic          rsp_valid_i,
  input  logic [CW-1:0] outs_i
);

  // The credit rule must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_i && !pop_i));

  // Every response must belong to a request that is still counted in flight.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_valid_i && (outs_i == {CW{1'b0}})));

endmodule

module ifetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic            misaligned
);

  // Pointer width, counter width (must hold FIFO_DEPTH itself) and one extra
  // bit so that fifo_count + outstanding cannot overflow before the compare.
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;

  localparam logic [CW:0]     DEPTH_C   = CW1'(FIFO_DEPTH);
  localparam logic [CW-1:0]   DEPTH_CW  = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Control state
  logic [1:0]      state_q,   state_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [CW-1:0]   outs_q,    outs_d;
  logic [CW-1:0]   drop_q,    drop_d;

  // Prefetch FIFO: instruction word plus the PC it was fetched from
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [PW-1:0]   fifo_rd_q,  fifo_rd_d;
  logic [PW-1:0]   fifo_wr_q,  fifo_wr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

  // Address queue: PCs of post-redirect requests still waiting for data
  logic [XLEN-1:0] aq_pc_q [FIFO_DEPTH];
  logic [PW-1:0]   aq_rd_q, aq_rd_d;
  logic [PW-1:0]   aq_wr_q, aq_wr_d;

  // Per-cycle qualifiers
  logic fifo_empty_s;
  logic fifo_full_s;
  logic credit_ok_s;
  logic req_valid_s;
  logic req_fire_s;
  logic drop_busy_s;
  logic rsp_keep_s;
  logic bypass_s;
  logic valid_s;
  logic pop_s;
  logic push_s;
  logic [CW-1:0] outs_next_s;

  // Handshake qualifiers and routing of this cycle's response.
  always_comb begin
    fifo_empty_s = (fifo_cnt_q == {CW{1'b0}});
    fifo_full_s  = (fifo_cnt_q == DEPTH_CW);
    // Buffered plus in-flight words may never exceed the FIFO size, so
    // every response is guaranteed a slot.
    credit_ok_s  = (({1'b0, fifo_cnt_q} + {1'b0, outs_q}) < DEPTH_C);
    req_valid_s  = rst_n & (state_q != ST_BOOT) & ~pc_sel & credit_ok_s;
    req_fire_s   = req_valid_s & imem_req_ready;
    drop_busy_s  = (drop_q != {CW{1'b0}});
    // A response landing in a redirect cycle is wrong-path and discarded.
    rsp_keep_s   = imem_rsp_valid & ~drop_busy_s & ~pc_sel;
`ifdef IFETCH_BYPASS_EN
    bypass_s     = rst_n & rsp_keep_s & fifo_empty_s;
`else
    bypass_s     = 1'b0;
`endif
    valid_s      = ~fifo_empty_s | bypass_s;
    pop_s        = ~fifo_empty_s & instr_ready;
    // A bypassed word taken by decode this cycle never enters the FIFO.
    push_s       = rsp_keep_s & ~(bypass_s & instr_ready);
  end

  // Next PC, in-flight/drop counters and FSM state; redirect wins over all.
  always_comb begin
    outs_next_s = outs_q + {{(CW-1){1'b0}}, req_fire_s}
                         - {{(CW-1){1'b0}}, imem_rsp_valid};
    outs_d      = outs_next_s;
    if (pc_sel) begin
      pc_d    = {pc_target[XLEN-1:2], 2'b00};
      // Everything still in flight after this cycle is wrong-path.
      drop_d  = outs_next_s;
      if (outs_next_s != {CW{1'b0}}) begin
        state_d = ST_FLUSH;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      if (req_fire_s) begin
        pc_d = pc_q + PC_STEP;
      end else begin
        pc_d = pc_q;
      end
      if (imem_rsp_valid && drop_busy_s) begin
        drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_d = drop_q;
      end
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN, ST_FLUSH: begin
          if (drop_d != {CW{1'b0}}) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
        // Unknown encoding: restart through BOOT, which issues nothing.
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // FIFO and address-queue pointer bookkeeping; a redirect empties both.
  always_comb begin
    if (pc_sel) begin
      fifo_rd_d  = {PW{1'b0}};
      fifo_wr_d  = {PW{1'b0}};
      fifo_cnt_d = {CW{1'b0}};
      aq_rd_d    = {PW{1'b0}};
      aq_wr_d    = {PW{1'b0}};
    end else begin
      if (pop_s) begin
        fifo_rd_d = fifo_rd_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        fifo_rd_d = fifo_rd_q;
      end
      if (push_s) begin
        fifo_wr_d = fifo_wr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        fifo_wr_d = fifo_wr_q;
      end
      fifo_cnt_d = fifo_cnt_q + {{(CW-1){1'b0}}, push_s}
                              - {{(CW-1){1'b0}}, pop_s};
      if (req_fire_s) begin
        aq_wr_d = aq_wr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        aq_wr_d = aq_wr_q;
      end
      // Only kept responses consume an address; dropped ones were never
      // recorded after the flush.
      if (rsp_keep_s) begin
        aq_rd_d = aq_rd_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        aq_rd_d = aq_rd_q;
      end
    end
  end

  // Decode-facing outputs: FIFO head, bypassed response, or a NOP when idle.
  always_comb begin
    if (!fifo_empty_s) begin
      instr    = fifo_data_q[fifo_rd_q];
      instr_pc = fifo_pc_q[fifo_rd_q];
    end else if (bypass_s) begin
      instr    = imem_rsp_data;
      instr_pc = aq_pc_q[aq_rd_q];
    end else begin
      instr    = NOP_INSTR;
      instr_pc = {XLEN{1'b0}};
    end
  end

  assign instr_valid    = valid_s;
  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_q;
  assign misaligned     = rst_n & pc_sel & (pc_target[1:0] != 2'b00);

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      outs_q     <= {CW{1'b0}};
      drop_q     <= {CW{1'b0}};
      fifo_rd_q  <= {PW{1'b0}};
      fifo_wr_q  <= {PW{1'b0}};
      fifo_cnt_q <= {CW{1'b0}};
      aq_rd_q    <= {PW{1'b0}};
      aq_wr_q    <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      aq_rd_q    <= aq_rd_d;
      aq_wr_q    <= aq_wr_d;
    end
  end

  // FIFO and address-queue storage writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= {XLEN{1'b0}};
        fifo_pc_q[i]   <= {XLEN{1'b0}};
        aq_pc_q[i]     <= {XLEN{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_data_q[fifo_wr_q] <= imem_rsp_data;
        fifo_pc_q[fifo_wr_q]   <= aq_pc_q[aq_rd_q];
      end
      if (req_fire_s) begin
        aq_pc_q[aq_wr_q] <= pc_q;
      end
    end
  end

  ifetch_unit_chk #(
    .CW (CW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .full_i      (fifo_full_s),
    .rsp_valid_i (imem_rsp_valid),
    .outs_i      (outs_q)
  );

endmodule
